// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types, fetch state encoding and helpers for the IF stage
package fetch_unit_pkg;

  typedef logic [63:0] word_t;
  typedef logic [31:0] inst_t;

  localparam inst_t NOP_INST = 32'd0;

  typedef enum logic [1:0] {
    FETCH_BOOT = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_HALT = 2'd2
  } fetch_state_e;

  // Instruction fetches are word aligned; the low two address bits are dropped.
  function automatic word_t align_word(input word_t addr);
    return {addr[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - IF stage bundle: hazard/branch controls, inst_mem port, IF/ID outputs
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic  stall_i;
  logic  branch_taken_i;
  word_t branch_target_i;
  inst_t inst_i;
  word_t pc_o;
  word_t ifid_pc_o;
  inst_t ifid_inst_o;
  logic  ifid_valid_o;
  logic  halted_o;
  logic  misalign_o;

  modport master (
    input  stall_i, branch_taken_i, branch_target_i, inst_i,
    output pc_o, ifid_pc_o, ifid_inst_o, ifid_valid_o, halted_o, misalign_o
  );

  modport slave (
    output stall_i, branch_taken_i, branch_target_i, inst_i,
    input  pc_o, ifid_pc_o, ifid_inst_o, ifid_valid_o, halted_o, misalign_o
  );

endinterface

// File: rtl/fetch_unit_ifid_reg.sv
// rtl/fetch_unit_ifid_reg.sv - pipeline register with flush > hold > load > bubble priority
module fetch_unit_ifid_reg #(
  parameter int unsigned       PC_W   = 64,
  parameter int unsigned       INST_W = 32,
  parameter logic [INST_W-1:0] NOP    = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              load_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [INST_W-1:0] inst_i,
  output logic [PC_W-1:0]   pc_o,
  output logic [INST_W-1:0] inst_o,
  output logic              valid_o
);

  logic [PC_W-1:0]   pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              valid_q, valid_d;

  // A flush keeps the PC field so downstream debug still sees where the bubble came from.
  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    if (flush_i) begin
      inst_d  = NOP;
      valid_d = 1'b0;
    end else if (!stall_i) begin
      if (load_i) begin
        pc_d    = pc_i;
        inst_d  = inst_i;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      inst_q  <= NOP;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
    end
  end

  assign pc_o    = pc_q;
  assign inst_o  = inst_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - LEGv8 IF stage: PC register, boot/run/halt control, IF/ID capture
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter word_t       RESET_PC    = 64'd0,
  parameter int unsigned BOOT_CYCLES = 3,
  parameter int unsigned MEM_BYTES   = 4096
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  localparam int unsigned CNT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BOOT_LAST =
    CNT_W'((BOOT_CYCLES == 0) ? 0 : BOOT_CYCLES - 1);
  localparam word_t MEM_END = word_t'(MEM_BYTES);

  fetch_state_e     state_q, state_d;
  word_t            pc_q, pc_d;
  logic [CNT_W-1:0] boot_cnt_q, boot_cnt_d;
  logic             halted_q, halted_d;
  logic             misalign_q, misalign_d;

  logic  ifid_flush;
  logic  ifid_stall;
  logic  ifid_load;
  logic  boot_done;
  word_t pc_inc;

  assign pc_inc    = pc_q + 64'd4;
  assign boot_done = (BOOT_CYCLES == 0) || (boot_cnt_q == BOOT_LAST);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    boot_cnt_d = boot_cnt_q;
    halted_d   = halted_q;
    misalign_d = misalign_q;
    ifid_flush = 1'b0;
    ifid_stall = 1'b1;
    ifid_load  = 1'b0;

    // A taken branch outranks any stall in both RUN and HALT.
    if (state_q != FETCH_BOOT && bus.branch_taken_i) begin
      pc_d       = align_word(bus.branch_target_i);
      ifid_flush = 1'b1;
      halted_d   = 1'b0;
      state_d    = FETCH_RUN;
      if (bus.branch_target_i[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
    end else begin
      case (state_q)
        FETCH_BOOT: begin
          boot_cnt_d = boot_cnt_q + 1'b1;
          if (boot_done) begin
            state_d = FETCH_RUN;
          end
        end
        FETCH_RUN: begin
          if (!bus.stall_i) begin
            ifid_stall = 1'b0;
            ifid_load  = 1'b1;
            if (pc_inc == MEM_END) begin
              state_d  = FETCH_HALT;
              halted_d = 1'b1;
            end else begin
              pc_d = pc_inc;
            end
          end
        end
        FETCH_HALT: begin
          ifid_stall = bus.stall_i;
        end
        default: begin
          state_d = FETCH_BOOT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH_BOOT;
      pc_q       <= RESET_PC;
      boot_cnt_q <= '0;
      halted_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      boot_cnt_q <= boot_cnt_d;
      halted_q   <= halted_d;
      misalign_q <= misalign_d;
    end
  end

  fetch_unit_ifid_reg #(
    .PC_W  (64),
    .INST_W(32),
    .NOP   (NOP_INST)
  ) u_ifid (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush_i(ifid_flush),
    .stall_i(ifid_stall),
    .load_i (ifid_load),
    .pc_i   (pc_q),
    .inst_i (bus.inst_i),
    .pc_o   (bus.ifid_pc_o),
    .inst_o (bus.ifid_inst_o),
    .valid_o(bus.ifid_valid_o)
  );

  assign bus.pc_o       = pc_q;
  assign bus.halted_o   = halted_q;
  assign bus.misalign_o = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed plan plus randomized run against a behavioural IF-stage model
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int unsigned MEM_B = 64;
  localparam int          BOOT  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if bus ();
  logic [31:0] mem [0:255];
  assign bus.inst_i = mem[bus.pc_o[9:2]];

  fetch_unit #(
    .RESET_PC   (64'd0),
    .BOOT_CYCLES(BOOT),
    .MEM_BYTES  (MEM_B)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int err_cnt = 0;
  int chk_cnt = 0;

  logic [63:0] m_pc, m_ifpc;
  logic [31:0] m_ifinst;
  bit          m_valid, m_halted, m_mis;
  int          m_boot_left;
  logic [63:0] tgt;
  bit          st, br;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 64'd0; m_ifpc = 64'd0; m_ifinst = 32'd0;
    m_valid = 1'b0; m_halted = 1'b0; m_mis = 1'b0;
    m_boot_left = (BOOT == 0) ? 1 : BOOT;
  endtask

  // One clock of IF-stage behaviour, stated from the stage rules rather than the state encoding.
  task automatic model_step(input bit s, input bit b, input logic [63:0] t);
    if (m_boot_left > 0) begin
      m_boot_left--;
    end else if (b) begin
      m_pc = t & ~64'd3;
      m_valid = 1'b0;
      m_ifinst = 32'd0;
      m_halted = 1'b0;
      if (t[1:0] != 2'b00) m_mis = 1'b1;
    end else if (m_halted) begin
      if (!s) m_valid = 1'b0;
    end else if (!s) begin
      m_ifpc = m_pc;
      m_ifinst = mem[m_pc[9:2]];
      m_valid = 1'b1;
      if (m_pc + 64'd4 == 64'(MEM_B)) m_halted = 1'b1;
      else m_pc = m_pc + 64'd4;
    end
  endtask

  task automatic check_all(input string where);
    check_eq({where, ".pc"},     bus.pc_o, m_pc);
    check_eq({where, ".ifpc"},   bus.ifid_pc_o, m_ifpc);
    check_eq({where, ".ifinst"}, 64'(bus.ifid_inst_o), 64'(m_ifinst));
    check_eq({where, ".valid"},  64'(bus.ifid_valid_o), 64'(m_valid));
    check_eq({where, ".halted"}, 64'(bus.halted_o), 64'(m_halted));
    check_eq({where, ".mis"},    64'(bus.misalign_o), 64'(m_mis));
  endtask

  task automatic cycle(input bit s, input bit b, input logic [63:0] t, input string where);
    bus.stall_i = s;
    bus.branch_taken_i = b;
    bus.branch_target_i = t;
    model_step(s, b, t);
    @(posedge clk);
    #1;
    check_all(where);
  endtask

  initial begin
    bus.stall_i = 1'b0;
    bus.branch_taken_i = 1'b0;
    bus.branch_target_i = 64'd0;
    for (int i = 0; i < 256; i++) mem[i] = 32'(i);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // Boot wait: a branch during boot must be ignored.
    cycle(0, 0, 64'd0, "boot");
    cycle(1, 1, 64'h40, "boot_ign");
    cycle(0, 0, 64'd0, "boot");
    check_eq("boot_pc", bus.pc_o, 64'd0);
    check_eq("boot_valid", 64'(bus.ifid_valid_o), 64'd0);
    cycle(0, 0, 64'd0, "first");
    check_eq("first_inst", 64'(bus.ifid_inst_o), 64'd0);
    check_eq("first_valid", 64'(bus.ifid_valid_o), 64'd1);
    repeat (3) cycle(0, 0, 64'd0, "seq");
    check_eq("seq_pc", bus.pc_o, 64'h10);

    repeat (2) begin
      cycle(1, 0, 64'd0, "stall");
      check_eq("stall_pc", bus.pc_o, 64'h10);
      check_eq("stall_inst", 64'(bus.ifid_inst_o), 64'd3);
      check_eq("stall_valid", 64'(bus.ifid_valid_o), 64'd1);
    end
    cycle(0, 0, 64'd0, "release");
    check_eq("release_inst", 64'(bus.ifid_inst_o), 64'd4);
    cycle(0, 0, 64'd0, "seq");
    check_eq("pre_br_pc", bus.pc_o, 64'h18);

    cycle(1, 1, 64'h40, "br_stall");
    check_eq("br_pc", bus.pc_o, 64'h40);
    check_eq("br_flush", 64'(bus.ifid_valid_o), 64'd0);
    cycle(0, 0, 64'd0, "after_br");
    check_eq("br_inst", 64'(bus.ifid_inst_o), 64'd16);
    check_eq("br_ifpc", bus.ifid_pc_o, 64'h40);

    cycle(0, 1, 64'h22, "misalign");
    check_eq("mis_pc", bus.pc_o, 64'h20);
    check_eq("mis_flag", 64'(bus.misalign_o), 64'd1);
    cycle(0, 1, 64'h0, "aligned_br");
    check_eq("mis_sticky", 64'(bus.misalign_o), 64'd1);

    repeat (16) cycle(0, 0, 64'd0, "to_end");
    check_eq("end_inst", 64'(bus.ifid_inst_o), 64'd15);
    check_eq("end_halted", 64'(bus.halted_o), 64'd1);
    check_eq("end_pc", bus.pc_o, 64'h3C);
    cycle(0, 0, 64'd0, "halt");
    check_eq("halt_valid", 64'(bus.ifid_valid_o), 64'd0);
    check_eq("halt_pc", bus.pc_o, 64'h3C);
    cycle(0, 1, 64'h0, "halt_br");
    check_eq("resume_halted", 64'(bus.halted_o), 64'd0);
    cycle(0, 0, 64'd0, "resume");
    check_eq("resume_inst", 64'(bus.ifid_inst_o), 64'd0);
    check_eq("resume_valid", 64'(bus.ifid_valid_o), 64'd1);
    repeat (11) cycle(0, 0, 64'd0, "seq2");
    check_eq("pre_rst_pc", bus.pc_o, 64'h30);

    // Asynchronous reset between edges.
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    check_eq("async_rst_mis", 64'(bus.misalign_o), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) begin
      cycle(0, 0, 64'd0, "reboot");
      check_eq("reboot_valid", 64'(bus.ifid_valid_o), 64'd0);
    end
    cycle(0, 0, 64'd0, "reboot_first");
    check_eq("reboot_valid1", 64'(bus.ifid_valid_o), 64'd1);

    // Randomized traffic with random memory contents.
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    for (int n = 0; n < 800; n++) begin
      st = ($urandom_range(0, 3) == 0);
      br = ($urandom_range(0, 11) == 0);
      tgt = 64'($urandom_range(0, 23)) << 2;
      if ($urandom_range(0, 15) == 0) tgt = tgt | 64'($urandom_range(1, 3));
      if ($urandom_range(0, 31) == 0) tgt[63:32] = $urandom;
      cycle(st, br, tgt, "rand");
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- IF stage of the LEGv8 pipeline. Owns the program counter, drives the address into the combinational instruction memory (inst_mem) and captures the returned word into the IF/ID pipeline register for decode.
- Handles a post-reset boot wait, decode stalls, taken-branch redirect/flush, and halting at the end of instruction memory.

Parameters:
- RESET_PC, 64'd0, PC value loaded on reset.
- BOOT_CYCLES, 3, cycles held in BOOT after reset deassertion before the first fetch (0 allowed).
- MEM_BYTES, 4096, instruction memory size in bytes; fetch halts at this boundary.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- stall_i  input  1  hazard unit: hold PC and IF/ID.
- branch_taken_i  input  1  EX stage: redirect fetch this cycle.
- branch_target_i  input  `WORD  redirect byte address.
- inst_i  input  `INST_SIZE  instruction from inst_mem for pc_o.
- pc_o  output  `WORD  fetch address to inst_mem.
- ifid_pc_o  output  `WORD  PC of the instruction held in IF/ID.
- ifid_inst_o  output  `INST_SIZE  instruction held in IF/ID.
- ifid_valid_o  output  1  IF/ID holds a real instruction.
- halted_o  output  1  fetch stopped at end of memory.
- misalign_o  output  1  sticky: a branch target had bits [1:0] != 0.

Behaviour:
- Reset (async, rst_n=0):
  - pc_o=RESET_PC; ifid_pc_o=0; ifid_inst_o=0; ifid_valid_o=0; halted_o=0; misalign_o=0.
  - State=BOOT, boot counter=0.
  - Reset asserted mid-operation clears everything immediately, without waiting for a clock edge.
- States: BOOT, RUN, HALT (2-bit encoding).
- BOOT:
  - Counter increments each clock. PC is held and ifid_valid_o stays 0.
  - Moves to RUN on the edge where counter==BOOT_CYCLES-1. With BOOT_CYCLES=0, moves on the first edge.
  - stall_i and branch inputs are ignored.
- RUN, priority branch > stall > advance:
  - Branch: pc_o<={target[63:2],2'b00}; ifid_valid_o<=0 (flush); ifid_inst_o<=0. If target[1:0]!=0, misalign_o<=1.
  - Stall (no branch): pc_o and all IF/ID outputs hold.
  - Advance: ifid_pc_o<=pc_o; ifid_inst_o<=inst_i; ifid_valid_o<=1; pc_o<=pc_o+4.
  - Advance with pc_o+4==MEM_BYTES: capture as usual, pc_o holds, next state HALT, halted_o<=1.
- HALT:
  - pc_o holds.
  - Non-stalled edge: ifid_valid_o<=0. Stalled edge: IF/ID holds.
  - Branch: redirect exactly as in RUN, halted_o<=0, next state RUN.
- Timing and arithmetic:
  - Fetch latency: an instruction appears on ifid_* one edge after pc_o presents its address.
  - PC add is 64-bit modulo 2^64; no other wrap handling.
  - Branch target >= MEM_BYTES is accepted and not checked.
- Simultaneous stall_i and branch_taken_i: branch wins. A flush always overrides a stall.
- misalign_o is cleared only by reset.

Decomposition:
- common.vh already supplies `WORD, `INST_SIZE, `HALF_CYCLE, `TB_BEGIN/`TB_END.
- Add to common.vh:
  - fetch state encodings FETCH_BOOT=2'd0, FETCH_RUN=2'd1, FETCH_HALT=2'd2.
  - `NOP_INST=32'd0.
- One sub-module is natural: ifid_reg, the IF/ID pipeline register with hold (stall) and clear (flush) controls. It will be reused for the later pipeline registers.
- The PC register and state machine stay in fetch_unit.

Test Plan:
- Boot and sequential fetch: rst_n low 2 cycles then high; inst_mem loaded with word n = n; no stall/branch.
  - pc_o stays 0 for 3 edges.
  - Then ifid_inst_o = 0,1,2,… with ifid_pc_o = 0,4,8,… and ifid_valid_o=1 from the 4th edge.
- Stall: assert stall_i for 2 cycles while pc_o=0x10.
  - pc_o stays 0x10; ifid_inst_o stays 3; ifid_valid_o stays 1.
  - After release, ifid_inst_o=4.
- Branch and flush: branch_taken_i=1, target=0x40, at pc_o=0x18, with stall_i=1 in the same cycle.
  - Next edge: pc_o=0x40, ifid_valid_o=0.
  - Following edge: ifid_inst_o=16, ifid_pc_o=0x40.
- Misaligned target: target=0x22.
  - pc_o=0x20; misalign_o=1 and it remains 1 after later aligned branches.
- End of memory: MEM_BYTES=64, run sequentially.
  - ifid_inst_o=15 captured; halted_o=1; pc_o holds 0x3C; ifid_valid_o=0 on the next edge.
  - Then branch to 0x0: halted_o=0 and fetch resumes with inst 0.
- Reset mid-run: drop rst_n asynchronously between edges at pc_o=0x30.
  - All outputs return to reset values immediately; BOOT wait repeats after release.
